// File: rtl/ace_mem_responder_if.sv
// ACE port bundle between one initiator (modport m) and one responder (modport s).
// Carries the AW/W/B/AR/R request channels plus the AC/CR/CD snoop channels and rack/wack.
interface ace_if #(
  parameter int ACE_AXADDR_WIDTH = 32,
  parameter int ACE_XDATA_WIDTH  = 64,
  parameter int ACE_ID_WIDTH     = 4
);
  logic                          awvalid, awready, awlock;
  logic [ACE_ID_WIDTH-1:0]       awid;
  logic [ACE_AXADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                    awlen;
  logic [2:0]                    awsize, awprot, awsnoop;
  logic [1:0]                    awburst, awdomain, awbar;
  logic [3:0]                    awcache, awqos, awregion;

  logic                          wvalid, wready, wlast;
  logic [ACE_XDATA_WIDTH-1:0]    wdata;
  logic [ACE_XDATA_WIDTH/8-1:0]  wstrb;

  logic                          bvalid, bready;
  logic [ACE_ID_WIDTH-1:0]       bid;
  logic [1:0]                    bresp;

  logic                          arvalid, arready, arlock;
  logic [ACE_ID_WIDTH-1:0]       arid;
  logic [ACE_AXADDR_WIDTH-1:0]   araddr;
  logic [7:0]                    arlen;
  logic [2:0]                    arsize, arprot;
  logic [1:0]                    arburst, ardomain, arbar;
  logic [3:0]                    arcache, arqos, arregion, arsnoop;

  logic                          rvalid, rready, rlast;
  logic [ACE_ID_WIDTH-1:0]       rid;
  logic [ACE_XDATA_WIDTH-1:0]    rdata;
  logic [3:0]                    rresp;

  logic                          acvalid, acready;
  logic [ACE_AXADDR_WIDTH-1:0]   acaddr;
  logic [3:0]                    acsnoop;
  logic [2:0]                    acprot;

  logic                          crvalid, crready;
  logic [4:0]                    crresp;

  logic                          cdvalid, cdready, cdlast;
  logic [ACE_XDATA_WIDTH-1:0]    cddata;

  logic                          rack, wack;

  modport m (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awsnoop, awdomain, awbar,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arsnoop, ardomain, arbar,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    input  acvalid, acaddr, acsnoop, acprot,
    output acready,
    output crvalid, crresp,
    input  crready,
    output cdvalid, cddata, cdlast,
    input  cdready,
    output rack, wack
  );

  modport s (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awsnoop, awdomain, awbar,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arsnoop, ardomain, arbar,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    output acvalid, acaddr, acsnoop, acprot,
    input  acready,
    input  crvalid, crresp,
    output crready,
    input  cdvalid, cddata, cdlast,
    output cdready,
    input  rack, wack
  );
endinterface

// File: rtl/ace_mem_responder.sv
// Single-beat ACE responder over an internal block-wide SRAM; answers no snoops.
// Define ACE_MEM_RESP_DELAY_EN to hold R/B valid back for RESP_DELAY extra cycles.
module ace_mem_responder #(
  parameter int unsigned MEM_BLOCKS = 1024,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned RESP_DELAY = 4
) (
  input  logic clk,
  input  logic rst,
  ace_if.s     mem_ace_if
);
  localparam int ADDR_WIDTH = $bits(mem_ace_if.araddr);
  localparam int BLOCK_SIZE = $bits(mem_ace_if.rdata);
  localparam int ID_WIDTH   = $bits(mem_ace_if.rid);
  localparam int unsigned NBYTES = BLOCK_SIZE / 8;
  localparam int BLOCK_OFFSET_WIDTH = $clog2(NBYTES);
  localparam int IDX_W = $clog2(MEM_BLOCKS);

  localparam logic [ADDR_WIDTH-1:0] BASE_LO = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH:0]   BASE    = {1'b0, BASE_LO};
  localparam logic [ADDR_WIDTH:0]   LIMIT   = BASE + (ADDR_WIDTH+1)'(MEM_BLOCKS * NBYTES);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, RD_RESP, WR_DATA, WR_RESP} state_t;

  state_t state_q, state_d;
  logic   out_en_q;
  logic   last_wr_q;
  logic [ID_WIDTH-1:0]   rid_q, bid_q;
  logic [BLOCK_SIZE-1:0] rdata_q;
  logic [1:0]            rresp_q, bresp_q;
  logic [IDX_W-1:0]      wr_idx_q;

  logic [BLOCK_SIZE-1:0] mem [MEM_BLOCKS];

  logic collide, idle_rdy, ar_hs, aw_hs, w_hs, r_hs, b_hs, resp_go;
  logic [1:0]       ar_code, aw_code;
  logic [IDX_W-1:0] ar_idx, aw_idx;

  function automatic logic [1:0] decode(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [7:0] len);
    logic [ADDR_WIDTH:0] a;
    a = {1'b0, addr};
    if (a < BASE || a >= LIMIT) return DECERR;
    if (len != 8'd0) return SLVERR;
    return OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_LO;
    return IDX_W'(off >> BLOCK_OFFSET_WIDTH);
  endfunction

  assign ar_code = decode(mem_ace_if.araddr, mem_ace_if.arlen);
  assign aw_code = decode(mem_ace_if.awaddr, mem_ace_if.awlen);
  assign ar_idx  = index_of(mem_ace_if.araddr);
  assign aw_idx  = index_of(mem_ace_if.awaddr);

  // Readys come from registered state; only a same-cycle AR/AW collision
  // masks the loser, with last_wr_q deciding which side that is.
  assign collide  = mem_ace_if.arvalid && mem_ace_if.awvalid;
  assign idle_rdy = out_en_q && (state_q == IDLE);
  assign mem_ace_if.arready = idle_rdy && !(collide && !last_wr_q);
  assign mem_ace_if.awready = idle_rdy && !(collide && last_wr_q);
  assign mem_ace_if.wready  = (state_q == WR_DATA);
  assign mem_ace_if.rvalid  = (state_q == RD_RESP) && resp_go;
  assign mem_ace_if.bvalid  = (state_q == WR_RESP) && resp_go;
  assign mem_ace_if.rlast   = (state_q == RD_RESP);
  assign mem_ace_if.rid     = rid_q;
  assign mem_ace_if.rdata   = rdata_q;
  assign mem_ace_if.rresp   = {2'b00, rresp_q};
  assign mem_ace_if.bid     = bid_q;
  assign mem_ace_if.bresp   = bresp_q;

  assign mem_ace_if.acvalid = 1'b0;
  assign mem_ace_if.acaddr  = '0;
  assign mem_ace_if.acsnoop = '0;
  assign mem_ace_if.acprot  = '0;
  assign mem_ace_if.crready = 1'b1;
  assign mem_ace_if.cdready = 1'b1;

  assign ar_hs = mem_ace_if.arvalid && mem_ace_if.arready;
  assign aw_hs = mem_ace_if.awvalid && mem_ace_if.awready;
  assign w_hs  = mem_ace_if.wvalid  && mem_ace_if.wready;
  assign r_hs  = mem_ace_if.rvalid  && mem_ace_if.rready;
  assign b_hs  = mem_ace_if.bvalid  && mem_ace_if.bready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ar_hs)      state_d = RD_RESP;
        else if (aw_hs) state_d = WR_DATA;
      end
      RD_RESP: if (r_hs) state_d = IDLE;
      WR_DATA: if (w_hs) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      out_en_q  <= 1'b0;
      last_wr_q <= 1'b1;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      bid_q     <= '0;
      bresp_q   <= OKAY;
      wr_idx_q  <= '0;
    end else begin
      state_q  <= state_d;
      out_en_q <= 1'b1;
      if (ar_hs) begin
        last_wr_q <= 1'b0;
        rid_q     <= mem_ace_if.arid;
        rresp_q   <= ar_code;
        rdata_q   <= (ar_code == OKAY) ? mem[ar_idx] : '0;
      end
      if (aw_hs) begin
        last_wr_q <= 1'b1;
        bid_q     <= mem_ace_if.awid;
        bresp_q   <= aw_code;
        wr_idx_q  <= aw_idx;
      end
    end
  end

  // Array is not reset; a write commits only on an OKAY W handshake out of reset.
  always_ff @(posedge clk) begin
    if (rst && w_hs && bresp_q == OKAY) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (mem_ace_if.wstrb[i]) mem[wr_idx_q][8*i +: 8] <= mem_ace_if.wdata[8*i +: 8];
      end
    end
  end

`ifdef ACE_MEM_RESP_DELAY_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_d != state_q && (state_d == RD_RESP || state_d == WR_RESP)) begin
      cnt_q <= 8'(RESP_DELAY);
    end else if (cnt_q != 8'd0) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign resp_go = (cnt_q == 8'd0);
`else
  assign resp_go = 1'b1;
`endif
endmodule
